// File: rtl/axis_ramp_source.sv
// axis_ramp_source: AXI4-Stream master emitting one packet per gen_en request.
// Beat k of a packet carries gen_start + k*gen_step (two's complement, wrapping).
// Control follows a level-enable / sticky-finished handshake: the finished flag
// stays up until gen_en drops, so one request yields exactly one packet.
module axis_ramp_source #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  gen_en,
  input  logic [DATA_WIDTH-1:0] gen_start,
  input  logic [DATA_WIDTH-1:0] gen_step,
  input  logic [LEN_WIDTH-1:0]  gen_length,
  output logic                  gen_busy,
  output logic                  gen_finished,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [KEEP_WIDTH-1:0] KEEP_ALL  = {KEEP_WIDTH{1'b1}};
  localparam logic [KEEP_WIDTH-1:0] KEEP_NONE = {KEEP_WIDTH{1'b0}};

  state_t                state_q,  state_d;
  logic [LEN_WIDTH-1:0]  cnt_q,    cnt_d;
  logic [LEN_WIDTH-1:0]  len_q,    len_d;
  logic [DATA_WIDTH-1:0] step_q,   step_d;
  logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q,  tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q,  tlast_d;
  logic                  busy_q,   busy_d;
  logic                  fin_q,    fin_d;

  // Next-state and next-output computation for the IDLE/SEND/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    step_d   = step_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    fin_d    = fin_q;

    case (state_q)
      ST_IDLE: begin
        if (gen_en) begin
          if (gen_length != LEN_ZERO) begin
            // Launch: the first beat is presented on the very next edge.
            state_d  = ST_SEND;
            cnt_d    = LEN_ZERO;
            len_d    = gen_length;
            step_d   = gen_step;
            tdata_d  = gen_start;
            tkeep_d  = KEEP_ALL;
            tvalid_d = 1'b1;
            tlast_d  = (gen_length == LEN_ONE);
            busy_d   = 1'b1;
            fin_d    = 1'b0;
          end else begin
            // Empty packet: nothing goes on the bus, just report completion.
            state_d = ST_DONE;
            fin_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        // gen_en is deliberately ignored here: an AXIS packet cannot be cut short.
        if (tvalid_q && m_axis_tready) begin
          if (tlast_q) begin
            state_d  = ST_DONE;
            cnt_d    = LEN_ZERO;
            tdata_d  = DATA_ZERO;
            tkeep_d  = KEEP_NONE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            fin_d    = 1'b1;
          end else begin
            cnt_d   = cnt_q + LEN_ONE;
            tdata_d = tdata_q + step_q;
            tlast_d = ((cnt_q + LEN_ONE) == (len_q - LEN_ONE));
          end
        end else begin
          // Stall: every beat field holds until the slave accepts it.
          state_d = ST_SEND;
        end
      end

      ST_DONE: begin
        if (!gen_en) begin
          state_d = ST_IDLE;
          fin_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = LEN_ZERO;
        tdata_d  = DATA_ZERO;
        tkeep_d  = KEEP_NONE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
        fin_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= LEN_ZERO;
      len_q    <= LEN_ZERO;
      step_q   <= DATA_ZERO;
      tdata_q  <= DATA_ZERO;
      tkeep_q  <= KEEP_NONE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      step_q   <= step_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      fin_q    <= fin_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign gen_busy      = busy_q;
  assign gen_finished  = fin_q;

endmodule

// File: tb/tb_axis_ramp_source.sv
// Self-checking bench for axis_ramp_source: directed scenarios plus randomized
// packets, compared against an arithmetic model (beat k = start + k*step).
module tb_axis_ramp_source;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        gen_en;
  logic [63:0] gen_start;
  logic [63:0] gen_step;
  logic [15:0] gen_length;
  logic        gen_busy;
  logic        gen_finished;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;

  int total  = 0;
  int passes = 0;

  axis_ramp_source #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .LEN_WIDTH(16)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .gen_en        (gen_en),
    .gen_start     (gen_start),
    .gen_step      (gen_step),
    .gen_length    (gen_length),
    .gen_busy      (gen_busy),
    .gen_finished  (gen_finished),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tvalid"}, {63'd0, m_axis_tvalid}, 64'd0);
    chk({tag, "_tdata"},  m_axis_tdata,           64'd0);
    chk({tag, "_tkeep"},  {56'd0, m_axis_tkeep},  64'd0);
    chk({tag, "_tlast"},  {63'd0, m_axis_tlast},  64'd0);
    chk({tag, "_busy"},   {63'd0, gen_busy},      64'd0);
  endtask

  // Run one packet request end to end.
  // mode 0: tready held high; 1: alternate stall/accept starting with a stall; 2: random tready.
  task automatic run_pkt(input logic [63:0] st, input logic [63:0] sp, input int len,
                         input int mode, input bit drop_en);
    logic [63:0] exp_q[$];
    int k;
    int cyc;
    bit phase;
    bit rdy;
    for (int i = 0; i < len; i++) exp_q.push_back(st + sp * 64'(i));

    gen_start     = st;
    gen_step      = sp;
    gen_length    = 16'(len);
    gen_en        = 1'b1;
    m_axis_tready = (mode == 0);
    tick();

    if (len == 0) begin
      chk("len0_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      chk("len0_fin",    {63'd0, gen_finished},  64'd1);
      chk("len0_busy",   {63'd0, gen_busy},      64'd0);
      tick();
      chk("len0_fin_hold",   {63'd0, gen_finished},  64'd1);
      chk("len0_tvalid_hold", {63'd0, m_axis_tvalid}, 64'd0);
      gen_en = 1'b0;
      tick();
      chk("len0_fin_clear", {63'd0, gen_finished}, 64'd0);
      return;
    end

    // Configuration changes after launch must not affect the running packet.
    gen_start  = {$urandom, $urandom};
    gen_step   = {$urandom, $urandom};
    gen_length = 16'($urandom);

    k = 0;
    cyc = 0;
    phase = 1'b0;
    while (k < len && cyc < 4 * len + 10) begin
      chk("beat_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
      chk("beat_tdata",  m_axis_tdata, exp_q[k]);
      chk("beat_tlast",  {63'd0, m_axis_tlast}, {63'd0, (k == len - 1)});
      chk("beat_tkeep",  {56'd0, m_axis_tkeep}, 64'hFF);
      chk("beat_busy",   {63'd0, gen_busy}, 64'd1);
      chk("beat_fin",    {63'd0, gen_finished}, 64'd0);
      case (mode)
        0: rdy = 1'b1;
        1: begin rdy = phase; phase = ~phase; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_axis_tready = rdy;
      if (drop_en && k == 0) gen_en = 1'b0;
      tick();
      if (rdy) k++;
      cyc++;
    end
    chk("beats_delivered", 64'(k), 64'(len));

    m_axis_tready = 1'($urandom_range(0, 1));
    chk_idle_outputs("post");
    chk("post_fin", {63'd0, gen_finished}, 64'd1);
    if (!drop_en) begin
      tick();
      chk("done_fin_hold",   {63'd0, gen_finished},  64'd1);
      chk("done_no_restart", {63'd0, m_axis_tvalid}, 64'd0);
      gen_en = 1'b0;
    end
    tick();
    chk("idle_fin_clear", {63'd0, gen_finished},  64'd0);
    chk("idle_tvalid",    {63'd0, m_axis_tvalid}, 64'd0);
    chk("idle_busy",      {63'd0, gen_busy},      64'd0);
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    gen_en        = 1'b0;
    gen_start     = 64'd0;
    gen_step      = 64'd0;
    gen_length    = 16'd0;
    m_axis_tready = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    chk("reset_fin", {63'd0, gen_finished}, 64'd0);
    sys_rst_n = 1'b1;
    tick();

    // 1: ramp 10, 0, -10 ... -80 at full throughput
    run_pkt(64'd10, -64'sd10, 10, 0, 1'b0);
    // 2: same packet under a 1-of-2 throttle
    run_pkt(64'd10, -64'sd10, 10, 1, 1'b0);
    // 3: zero-length request
    run_pkt(64'd3, 64'd1, 0, 0, 1'b0);
    // 4: single beat
    run_pkt(64'd5, 64'd7, 1, 0, 1'b0);
    // 5: signed wrap from max positive to min negative
    run_pkt(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2, 0, 1'b0);
    // gen_en dropped during SEND: packet still completes
    run_pkt(64'd100, 64'd3, 5, 2, 1'b1);

    // 6: reset after three beats of a ten-beat packet, then a clean rerun
    gen_start     = 64'd10;
    gen_step      = -64'sd10;
    gen_length    = 16'd10;
    gen_en        = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("pre_rst_tdata", m_axis_tdata, 64'd10 - 64'd10 * 64'(i));
      tick();
    end
    sys_rst_n = 1'b0;
    gen_en    = 1'b0;
    tick();
    chk_idle_outputs("midrst");
    chk("midrst_fin", {63'd0, gen_finished}, 64'd0);
    sys_rst_n = 1'b1;
    tick();
    chk("midrst_quiet", {63'd0, m_axis_tvalid}, 64'd0);
    run_pkt(64'd10, -64'sd10, 10, 0, 1'b0);

    // Randomized packets against the arithmetic model
    for (int n = 0; n < 20; n++) begin
      run_pkt({$urandom, $urandom}, {$urandom, $urandom},
              (n % 7 == 3) ? 0 : int'($urandom_range(1, 12)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
